duck_flock_ctrl: RTL and testbench

DUCK_FLOCK_CTRL -- requirements
Module: duck_flock_ctrl

---
 rtl/duck_flock_pkg.sv | 38 +++
 rtl/duck_flock_ctrl_duck_mover.sv | 116 +++++++++++
 rtl/duck_flock_ctrl.sv | 179 +++++++++++++++++
 tb/tb_duck_flock_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_flock_pkg.sv
// Shared types and default geometry for the duck flock controller.
// Enums give the encodings that appear on the duck_st, flash_mode and game_st ports.
package duck_flock_pkg;

  typedef enum logic [1:0] {
    FLYING = 2'd0,
    HIT    = 2'd1,
    LANDED = 2'd2
  } duck_st_t;

  typedef enum logic [1:0] {
    ZAP_IDLE  = 2'd0,
    ZAP_BLACK = 2'd1,
    ZAP_WHITE = 2'd2,
    ZAP_HELD  = 2'd3
  } zap_st_t;

  typedef enum logic [1:0] {
    START     = 2'd0,
    IN_GAME   = 2'd1,
    GAME_OVER = 2'd2
  } game_st_t;

  typedef enum logic [1:0] {
    FLASH_NORMAL = 2'd0,
    FLASH_BLACK  = 2'd1,
    FLASH_WHITE  = 2'd2
  } flash_t;

  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_BOX_W     = 50;
  localparam int DEF_BOX_H     = 50;
  localparam int SPRITE_PERIOD = 30;
  localparam int SPRITE_HALF   = 15;
  localparam int HIT_FALL      = 2;

endpackage

// File: rtl/duck_flock_ctrl_duck_mover.sv
// One duck: position, direction, flight state and relaunch timer.
// Moves one step per frame while step is high; hit and reload are single-frame strobes.
module duck_mover
  import duck_flock_pkg::*;
#(
  parameter int IDX          = 0,
  parameter int N_DUCKS      = 2,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int BOX_W        = DEF_BOX_W,
  parameter int BOX_H        = DEF_BOX_H,
  parameter int LANDED_DELAY = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       hit,
  input  logic       reload,
  input  logic [5:0] speed,
  output logic [9:0] x,
  output logic [9:0] y,
  output duck_st_t   st,
  output logic       fwd,
  output logic       landed
);

  localparam int         XMAX     = SCREEN_W - BOX_W;
  localparam int         YMAX     = SCREEN_H - BOX_H;
  localparam int         TW       = $clog2(LANDED_DELAY + 1);
  localparam logic [9:0] X_INIT   = 10'(IDX * (SCREEN_W / N_DUCKS));
  localparam logic [9:0] Y_INIT   = 10'(YMAX);
  localparam logic       FWD_INIT = ((IDX % 2) == 0);

  logic          down;
  logic [TW-1:0] timer;
  logic [10:0]   x_up;
  logic [10:0]   y_up;
  logic [10:0]   y_fall;

  // 11-bit sums so the clamp compare sees overflow past the screen edge
  assign x_up   = {1'b0, x} + {5'b0, speed};
  assign y_up   = {1'b0, y} + {5'b0, speed};
  assign y_fall = {1'b0, y} + 11'(HIT_FALL);
  assign landed = step && !reload && (st == HIT) && (y_fall >= 11'(YMAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= X_INIT;
      y     <= Y_INIT;
      st    <= FLYING;
      fwd   <= FWD_INIT;
      down  <= 1'b0;
      timer <= '0;
    end else if (reload) begin
      x     <= X_INIT;
      y     <= Y_INIT;
      st    <= FLYING;
      fwd   <= FWD_INIT;
      down  <= 1'b0;
      timer <= '0;
    end else if (hit) begin
      if (st == FLYING) st <= HIT;
    end else if (step) begin
      case (st)
        FLYING: begin
          if (fwd) begin
            if (x_up >= 11'(XMAX)) begin
              x   <= 10'(XMAX);
              fwd <= 1'b0;
            end else begin
              x <= x_up[9:0];
            end
          end else if (x < {4'b0, speed}) begin
            x   <= '0;
            fwd <= 1'b1;
          end else begin
            x <= x - {4'b0, speed};
          end
          if (down) begin
            if (y_up >= 11'(YMAX)) begin
              y    <= 10'(YMAX);
              down <= 1'b0;
            end else begin
              y <= y_up[9:0];
            end
          end else if (y < {4'b0, speed}) begin
            y    <= '0;
            down <= 1'b1;
          end else begin
            y <= y - {4'b0, speed};
          end
        end
        HIT: begin
          if (y_fall >= 11'(YMAX)) begin
            y  <= 10'(YMAX);
            st <= LANDED;
          end else begin
            y <= y_fall[9:0];
          end
        end
        LANDED: begin
          if (timer == TW'(LANDED_DELAY - 1)) begin
            st    <= FLYING;
            fwd   <= 1'b1;
            down  <= 1'b0;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: st <= FLYING;
      endcase
    end
  end

endmodule

// File: rtl/duck_flock_ctrl.sv
// Duck-hunt style game controller: game and zapper FSMs, scoring, levels,
// and a bank of duck_mover instances sharing one speed and sprite counter.
module duck_flock_ctrl
  import duck_flock_pkg::*;
#(
  parameter int N_DUCKS      = 2,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int BOX_W        = DEF_BOX_W,
  parameter int BOX_H        = DEF_BOX_H,
  parameter int SPEED_INIT   = 3,
  parameter int SPEED_MAX    = 15,
  parameter int LANDED_DELAY = 120,
  parameter int MAX_MISSES   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 trigger,
  input  logic                 detect,
  output logic [N_DUCKS*10-1:0] duck_x,
  output logic [N_DUCKS*10-1:0] duck_y,
  output logic [N_DUCKS*2-1:0]  duck_st,
  output logic [N_DUCKS-1:0]    duck_fwd,
  output logic [N_DUCKS*2-1:0]  sprite_sel,
  output logic [1:0]            flash_mode,
  output logic [1:0]            flash_idx,
  output logic [1:0]            game_st,
  output logic [7:0]            score,
  output logic [3:0]            level
);

  localparam int MW = $clog2(MAX_MISSES + 1);

  zap_st_t            zap;
  game_st_t           game;
  logic               trig_prev;
  logic [4:0]         frame_cnt;
  logic [MW-1:0]      misses;
  logic [N_DUCKS-1:0] landed_mask;
  logic [N_DUCKS-1:0] mask_next;
  logic [N_DUCKS-1:0] landed;
  logic [N_DUCKS-1:0] hit_vec;
  duck_st_t           st [N_DUCKS];
  logic [5:0]         speed_sum;
  logic [5:0]         speed;
  logic               step;
  logic               reload;
  logic               hit_any;
  logic               last_white;
  logic               miss_evt;
  logic               misses_full;
  logic [2:0]         land_cnt;
  logic [8:0]         score_sum;
  logic [7:0]         score_next;

  assign game_st     = game;
  assign step        = frame_tick && (zap == ZAP_IDLE || zap == ZAP_HELD);
  assign reload      = frame_tick && (game == GAME_OVER) && trigger && !trig_prev;
  assign hit_any     = |hit_vec;
  assign last_white  = (flash_idx == 2'(N_DUCKS - 1));
  assign miss_evt    = (zap == ZAP_WHITE) && !hit_any && last_white;
  assign misses_full = (32'(misses) + 32'd1) >= 32'(MAX_MISSES);
  assign speed_sum   = 6'(SPEED_INIT) + {2'b0, level};
  assign speed       = (speed_sum > 6'(SPEED_MAX)) ? 6'(SPEED_MAX) : speed_sum;

  // A sample only counts against the duck whose box is lit and still flying
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_DUCKS; i++) begin
      if (frame_tick && zap == ZAP_WHITE && detect && flash_idx == 2'(i) && st[i] == FLYING)
        hit_vec[i] = 1'b1;
    end
  end

  always_comb begin
    land_cnt = '0;
    for (int i = 0; i < N_DUCKS; i++) land_cnt = land_cnt + {2'b0, landed[i]};
    score_sum  = {1'b0, score} + {6'b0, land_cnt};
    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
    mask_next  = landed_mask | landed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game        <= START;
      zap         <= ZAP_IDLE;
      flash_mode  <= FLASH_NORMAL;
      flash_idx   <= '0;
      misses      <= '0;
      score       <= '0;
      level       <= '0;
      landed_mask <= '0;
      trig_prev   <= 1'b0;
      frame_cnt   <= '0;
    end else if (frame_tick) begin
      trig_prev <= trigger;
      frame_cnt <= (frame_cnt == 5'(SPRITE_PERIOD - 1)) ? '0 : frame_cnt + 5'd1;
      if (reload) begin
        game        <= START;
        zap         <= ZAP_IDLE;
        flash_mode  <= FLASH_NORMAL;
        flash_idx   <= '0;
        misses      <= '0;
        score       <= '0;
        level       <= '0;
        landed_mask <= '0;
      end else begin
        score <= score_next;
        if (&mask_next) begin
          landed_mask <= '0;
          if (level != 4'hF) level <= level + 4'd1;
        end else begin
          landed_mask <= mask_next;
        end
        // Zapper: black frame, one white frame per duck, then hold until release
        case (zap)
          ZAP_IDLE: begin
            if (game == IN_GAME && trigger) begin
              zap        <= ZAP_BLACK;
              flash_mode <= FLASH_BLACK;
            end
          end
          ZAP_BLACK: begin
            zap        <= ZAP_WHITE;
            flash_mode <= FLASH_WHITE;
            flash_idx  <= '0;
          end
          ZAP_WHITE: begin
            if (hit_any || last_white) begin
              zap        <= ZAP_HELD;
              flash_mode <= FLASH_NORMAL;
              flash_idx  <= '0;
              if (!hit_any) misses <= misses + 1'b1;
            end else begin
              flash_idx <= flash_idx + 2'd1;
            end
          end
          ZAP_HELD: begin
            if (!trigger) zap <= ZAP_IDLE;
          end
        endcase
        case (game)
          START:   if (trigger) game <= IN_GAME;
          IN_GAME: if (miss_evt && misses_full) game <= GAME_OVER;
          default: game <= game;
        endcase
      end
    end
  end

  for (genvar i = 0; i < N_DUCKS; i++) begin : g_duck
    duck_mover #(
      .IDX          (i),
      .N_DUCKS      (N_DUCKS),
      .SCREEN_W     (SCREEN_W),
      .SCREEN_H     (SCREEN_H),
      .BOX_W        (BOX_W),
      .BOX_H        (BOX_H),
      .LANDED_DELAY (LANDED_DELAY)
    ) u_mover (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (step),
      .hit    (hit_vec[i]),
      .reload (reload),
      .speed  (speed),
      .x      (duck_x[10*i +: 10]),
      .y      (duck_y[10*i +: 10]),
      .st     (st[i]),
      .fwd    (duck_fwd[i]),
      .landed (landed[i])
    );
    assign duck_st[2*i +: 2]    = st[i];
    assign sprite_sel[2*i +: 2] = (st[i] != FLYING) ? 2'd2 :
                                  (frame_cnt < 5'(SPRITE_HALF)) ? 2'd0 : 2'd1;
  end

endmodule

// File: tb/tb_duck_flock_ctrl.sv
// Self-checking bench for duck_flock_ctrl: directed scenarios plus random play,
// every frame compared against a frame-level behavioural model of the game.
module tb_duck_flock_ctrl;

  localparam int N     = 2;
  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int BW    = 50;
  localparam int BH    = 50;
  localparam int SP0   = 3;
  localparam int SPMAX = 15;
  localparam int DELAY = 120;
  localparam int MAXM  = 3;
  localparam int XLIM  = SW - BW;
  localparam int YLIM  = SH - BH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frame_tick;
  logic            trigger;
  logic            detect;
  logic [N*10-1:0] duck_x;
  logic [N*10-1:0] duck_y;
  logic [N*2-1:0]  duck_st;
  logic [N-1:0]    duck_fwd;
  logic [N*2-1:0]  sprite_sel;
  logic [1:0]      flash_mode;
  logic [1:0]      flash_idx;
  logic [1:0]      game_st;
  logic [7:0]      score;
  logic [3:0]      level;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = trigger free, 1 = black frame, 2..N+1 = white for duck phase-2, N+2 = held
  int m_x [N];
  int m_y [N];
  int m_fwd [N];
  int m_down [N];
  int m_st [N];
  int m_timer [N];
  bit m_landed_since [N];
  int m_game, m_phase, m_misses, m_score, m_level, m_fc, m_trig_prev;

  always #5 clk = ~clk;

  duck_flock_ctrl #(
    .N_DUCKS(N), .SCREEN_W(SW), .SCREEN_H(SH), .BOX_W(BW), .BOX_H(BH),
    .SPEED_INIT(SP0), .SPEED_MAX(SPMAX), .LANDED_DELAY(DELAY), .MAX_MISSES(MAXM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .trigger(trigger), .detect(detect),
    .duck_x(duck_x), .duck_y(duck_y), .duck_st(duck_st), .duck_fwd(duck_fwd),
    .sprite_sel(sprite_sel), .flash_mode(flash_mode), .flash_idx(flash_idx),
    .game_st(game_st), .score(score), .level(level)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic modelReset(input bit keep_frame);
    for (int i = 0; i < N; i++) begin
      m_x[i] = i * (SW / N);
      m_y[i] = YLIM;
      m_fwd[i] = (i % 2 == 0) ? 1 : 0;
      m_down[i] = 0;
      m_st[i] = 0;
      m_timer[i] = 0;
      m_landed_since[i] = 1'b0;
    end
    m_game = 0;
    m_phase = 0;
    m_misses = 0;
    m_score = 0;
    m_level = 0;
    if (!keep_frame) begin
      m_fc = 0;
      m_trig_prev = 0;
    end
  endtask

  task automatic stepAxis(inout int pos, inout int dir, input int spd, input int lim);
    int nxt;
    nxt = (dir != 0) ? pos + spd : pos - spd;
    if (nxt >= lim) begin
      pos = lim;
      dir = 0;
    end else if (nxt < 0) begin
      pos = 0;
      dir = 1;
    end else begin
      pos = nxt;
    end
  endtask

  task automatic modelTick(input bit trg, input bit det);
    int  spd, landings, k, g_old, p, d;
    bit  moving, restart, all_landed;
    spd = minInt(SP0 + m_level, SPMAX);
    restart = (m_game == 2) && trg && (m_trig_prev == 0);
    moving = (m_phase == 0) || (m_phase == N + 2);
    m_fc = (m_fc + 1) % 30;
    m_trig_prev = trg ? 1 : 0;
    if (restart) begin
      modelReset(1'b1);
      return;
    end
    g_old = m_game;
    landings = 0;
    if (m_phase == 0) begin
      if (g_old == 1 && trg) m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase <= N + 1) begin
      k = m_phase - 2;
      if (det && m_st[k] == 0) begin
        m_st[k] = 1;
        m_phase = N + 2;
      end else if (k == N - 1) begin
        m_misses++;
        m_phase = N + 2;
        if (g_old == 1 && m_misses >= MAXM) m_game = 2;
      end else begin
        m_phase++;
      end
    end else if (!trg) begin
      m_phase = 0;
    end
    if (g_old == 0 && trg) m_game = 1;
    if (moving) begin
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == 0) begin
          p = m_x[i]; d = m_fwd[i];
          stepAxis(p, d, spd, XLIM);
          m_x[i] = p; m_fwd[i] = d;
          p = m_y[i]; d = m_down[i];
          stepAxis(p, d, spd, YLIM);
          m_y[i] = p; m_down[i] = d;
        end else if (m_st[i] == 1) begin
          m_y[i] = m_y[i] + 2;
          if (m_y[i] >= YLIM) begin
            m_y[i] = YLIM;
            m_st[i] = 2;
            landings++;
            m_landed_since[i] = 1'b1;
          end
        end else begin
          m_timer[i]++;
          if (m_timer[i] == DELAY) begin
            m_st[i] = 0;
            m_fwd[i] = 1;
            m_down[i] = 0;
            m_timer[i] = 0;
          end
        end
      end
    end
    m_score = minInt(m_score + landings, 255);
    all_landed = 1'b1;
    for (int i = 0; i < N; i++) if (!m_landed_since[i]) all_landed = 1'b0;
    if (all_landed) begin
      m_level = minInt(m_level + 1, 15);
      for (int i = 0; i < N; i++) m_landed_since[i] = 1'b0;
    end
  endtask

  task automatic compareAll(input string tag);
    logic [N*10-1:0] ex, ey;
    logic [N*2-1:0]  est, espr;
    logic [N-1:0]    efwd;
    int              fm;
    for (int i = 0; i < N; i++) begin
      ex[10*i +: 10]  = 10'(m_x[i]);
      ey[10*i +: 10]  = 10'(m_y[i]);
      est[2*i +: 2]   = 2'(m_st[i]);
      efwd[i]         = (m_fwd[i] != 0);
      espr[2*i +: 2]  = (m_st[i] != 0) ? 2'd2 : ((m_fc < 15) ? 2'd0 : 2'd1);
    end
    fm = (m_phase == 1) ? 1 : ((m_phase >= 2 && m_phase <= N + 1) ? 2 : 0);
    checkOutput({tag, "/duck_x"}, 32'(duck_x), 32'(ex));
    checkOutput({tag, "/duck_y"}, 32'(duck_y), 32'(ey));
    checkOutput({tag, "/duck_st"}, 32'(duck_st), 32'(est));
    checkOutput({tag, "/duck_fwd"}, 32'(duck_fwd), 32'(efwd));
    checkOutput({tag, "/sprite_sel"}, 32'(sprite_sel), 32'(espr));
    checkOutput({tag, "/flash_mode"}, 32'(flash_mode), 32'(fm));
    if (fm == 2) checkOutput({tag, "/flash_idx"}, 32'(flash_idx), 32'(m_phase - 2));
    checkOutput({tag, "/game_st"}, 32'(game_st), 32'(m_game));
    checkOutput({tag, "/score"}, 32'(score), 32'(m_score));
    checkOutput({tag, "/level"}, 32'(level), 32'(m_level));
  endtask

  task automatic applyStimulus(input bit trg, input bit det);
    @(negedge clk);
    trigger = trg;
    detect = det;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    modelTick(trg, det);
    compareAll("frame");
  endtask

  task automatic idleCycle();
    @(negedge clk);
    frame_tick = 1'b0;
    trigger = 1'($urandom_range(0, 1));
    detect = 1'($urandom_range(0, 1));
    @(negedge clk);
    compareAll("idle");
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_tick = 1'b0;
    trigger = 1'b0;
    detect = 1'b0;
    modelReset(1'b0);
    @(negedge clk);
    compareAll("reset");
    rst_n = 1'b1;
  endtask

  // Holds the trigger through one flash sequence, detecting only on target's white frame
  task automatic fireShot(input int target);
    bit done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      applyStimulus(1'b1, m_phase == 2 + target);
      done = (m_phase == N + 2);
    end
    if (!done) checkOutput("shot_timeout", 32'd0, 32'd1);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic runUntilLanded(input int idx, input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      applyStimulus(1'b0, 1'b0);
      done = (m_st[idx] == 2);
    end
    if (!done) checkOutput(tag, 32'd0, 32'd1);
  endtask

  initial begin
    bit trg_r = 1'b0;
    rst_n = 1'b0;
    frame_tick = 1'b0;
    trigger = 1'b0;
    detect = 1'b0;
    modelReset(1'b0);
    repeat (3) @(negedge clk);
    compareAll("reset");
    checkOutput("rst_duck_x", 32'(duck_x), {12'd0, 10'd320, 10'd0});
    checkOutput("rst_duck_y", 32'(duck_y), {12'd0, 10'd430, 10'd430});
    checkOutput("rst_duck_fwd", 32'(duck_fwd), 32'h1);
    rst_n = 1'b1;

    repeat (5) idleCycle();
    checkOutput("hold_duck_x", 32'(duck_x), {12'd0, 10'd320, 10'd0});

    // Duck 0 starts at x=0 heading right at speed 3: reaches 588, bounces at 590, returns to 2, then 0
    for (int f = 1; f <= 400; f++) begin
      applyStimulus(1'b0, 1'b0);
      if (f == 196) checkOutput("pre_bounce_x", 32'(duck_x[9:0]), 32'd588);
      if (f == 197) begin
        checkOutput("bounce_r_x", 32'(duck_x[9:0]), 32'd590);
        checkOutput("bounce_r_fwd", 32'(duck_fwd[0]), 32'd0);
      end
      if (f == 393) checkOutput("pre_bounce_l_x", 32'(duck_x[9:0]), 32'd2);
      if (f == 394) begin
        checkOutput("bounce_l_x", 32'(duck_x[9:0]), 32'd0);
        checkOutput("bounce_l_fwd", 32'(duck_fwd[0]), 32'd1);
      end
    end

    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_game", 32'(game_st), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_black", 32'(flash_mode), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_white0", 32'({flash_mode, flash_idx}), 32'({2'd2, 2'd0}));
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_white1", 32'({flash_mode, flash_idx}), 32'({2'd2, 2'd1}));
    applyStimulus(1'b1, 1'b1);
    checkOutput("t3_duck1_hit", 32'(duck_st[3:2]), 32'd1);
    checkOutput("t3_flash_off", 32'(flash_mode), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t3_held_no_refire", 32'(flash_mode), 32'd0);
    applyStimulus(1'b0, 1'b0);

    runUntilLanded(1, "t5_land1_timeout");
    checkOutput("t5_score1", 32'(score), 32'd1);
    checkOutput("t5_landed", 32'(duck_st[3:2]), 32'd2);
    repeat (DELAY - 1) applyStimulus(1'b0, 1'b0);
    checkOutput("t5_still_landed", 32'(duck_st[3:2]), 32'd2);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_relaunch", 32'(duck_st[3:2]), 32'd0);
    checkOutput("t5_relaunch_fwd", 32'(duck_fwd[1]), 32'd1);
    fireShot(0);
    runUntilLanded(0, "t5_land0_timeout");
    checkOutput("t5_level1", 32'(level), 32'd1);
    checkOutput("t5_score2", 32'(score), 32'd2);
    repeat (20) applyStimulus(1'b0, 1'b0);

    for (int s = 0; s < 3; s++) fireShot(-1);
    checkOutput("t4_game_over", 32'(game_st), 32'd2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_restart", 32'(game_st), 32'd0);
    checkOutput("t4_score0", 32'(score), 32'd0);
    checkOutput("t4_level0", 32'(level), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idleCycle();
      end else begin
        if ($urandom_range(0, 3) == 0) trg_r = ~trg_r;
        applyStimulus(trg_r, 1'($urandom_range(0, 1)));
      end
    end

    pulseReset();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_in_white", 32'(flash_mode), 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_flash", 32'(flash_mode), 32'd0);
    modelReset(1'b0);
    compareAll("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    fireShot(-1);
    fireShot(-1);
    checkOutput("t6_no_miss_counted", 32'(game_st), 32'd1);
    fireShot(-1);
    checkOutput("t6_third_miss", 32'(game_st), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
